// File: rtl/code84_bcd_seq.sv
// Assembles NDIG serial 84-2-1 digits into a packed BCD word, first digit in the MS nibble.
// Invalid codes land as 4'hF and set a frame-sticky error flag.

module othertoBCD (
  input  logic [3:0] code_i,
  output logic [3:0] bcd_o,
  output logic       inv_o
);
  always_comb begin
    bcd_o = 4'hF;
    inv_o = 1'b0;
    case (code_i)
      4'b0000: bcd_o = 4'd0;
      4'b0111: bcd_o = 4'd1;
      4'b0110: bcd_o = 4'd2;
      4'b0101: bcd_o = 4'd3;
      4'b0100: bcd_o = 4'd4;
      4'b1011: bcd_o = 4'd5;
      4'b1010: bcd_o = 4'd6;
      4'b1001: bcd_o = 4'd7;
      4'b1000: bcd_o = 4'd8;
      4'b1111: bcd_o = 4'd9;
      default: inv_o = 1'b1;
    endcase
  end
endmodule

module code84_bcd_seq #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [4*NDIG-1:0] bcd_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  output logic              busy
);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] shift_q, shift_d, shift_in;
  logic              err_q, err_d;
  logic [3:0]        nib;
  logic              inv;

  othertoBCD u_conv (.code_i(din), .bcd_o(nib), .inv_o(inv));

  generate
    if (NDIG == 1) begin : g_one
      assign shift_in = nib;
    end else begin : g_many
      assign shift_in = {shift_q[4*NDIG-5:0], nib};
    end
  endgenerate

  // Handshake outputs decode the state register only.
  assign din_ready = (state_q == COLLECT);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign bcd_out   = shift_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    err_d   = err_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = COLLECT;
          cnt_d   = '0;
          shift_d = '0;
          err_d   = 1'b0;
        end
        COLLECT: if (din_valid && din_ready) begin
          shift_d = shift_in;
          err_d   = err_q | inv;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_code84_bcd_seq.sv
// Scoreboard bench for code84_bcd_seq: an NDIG=4 instance for frame scenarios and
// an NDIG=1 instance for the full code sweep. Inputs change on negedge, outputs sampled there too.

module tb_code84_bcd_seq;
  logic clk, rst_n;
  logic start, abort, din_valid, out_ready;
  logic [3:0] din;
  logic din_ready, out_valid, err, busy;
  logic [15:0] bcd_out;
  logic start1, abort1, din_valid1, out_ready1;
  logic [3:0] din1;
  logic din_ready1, out_valid1, err1, busy1;
  logic [3:0] bcd_out1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp;
  bit ok;

  code84_bcd_seq #(.NDIG(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .bcd_out(bcd_out),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .busy(busy));

  code84_bcd_seq #(.NDIG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .din(din1),
    .din_valid(din_valid1), .din_ready(din_ready1), .bcd_out(bcd_out1),
    .out_valid(out_valid1), .out_ready(out_ready1), .err(err1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode from the weights 8,4,-2,-1; anything outside 0..9 is invalid.
  function automatic logic [4:0] ref84(input logic [3:0] c);
    int a, b, cc, d, v;
    a = int'(c[3]); b = int'(c[2]); cc = int'(c[1]); d = int'(c[0]);
    v = 8*a + 4*b - 2*cc - d;
    if (v < 0 || v > 9) return {1'b1, 4'hF};
    return {1'b0, 4'(v)};
  endfunction

  task automatic drive_digit(input logic [3:0] d, input int gap);
    din_valid = 1'b0;
    repeat (gap) @(negedge clk);
    din = d; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic run_frame4(input logic [15:0] codes, input int maxgap);
    logic [15:0] b;
    logic e;
    logic [4:0] r;
    b = '0; e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = ref84(codes[15-4*i -: 4]);
      b = {b[11:0], r[3:0]};
      e = e | r[4];
    end
    exp_q.push_back({e, b});
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++)
      drive_digit(codes[15-4*i -: 4], int'($urandom_range(maxgap, 0)));
  endtask

  task automatic wait_valid4(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic handshake4();
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; abort = 0; din = 0; din_valid = 0; out_ready = 0;
    start1 = 0; abort1 = 0; din1 = 0; din_valid1 = 0; out_ready1 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({din_ready, out_valid, err, busy} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b want=0000", {din_ready, out_valid, err, busy}); end
    n_cmp++; if (bcd_out !== 16'h0) begin
      n_bad++; $display("FAIL reset_bcd got=%h want=0000", bcd_out); end
  endtask

  task automatic test_basic();
    run_frame4({4'b0111, 4'b0110, 4'b0101, 4'b0100}, 0);
    n_cmp++; if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL basic_latency out_valid got=%b want=1", out_valid); end
    wait_valid4(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== 16'h1234 || bcd_out !== exp[15:0] || err !== exp[16]) begin
      n_bad++; $display("FAIL basic_result bcd=%h err=%b want bcd=1234 err=%b", bcd_out, err, exp[16]); end
    handshake4();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle busy=%b out_valid=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_sweep();
    logic [4:0] r;
    for (int c = 0; c < 16; c++) begin
      r = ref84(4'(c));
      exp_q.push_back({r[4], 12'h0, r[3:0]});
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      din1 = 4'(c); din_valid1 = 1'b1; @(negedge clk); din_valid1 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid1) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || bcd_out1 !== exp[3:0] || err1 !== exp[16]) begin
        n_bad++; $display("FAIL sweep_code%0d bcd=%h err=%b want bcd=%h err=%b", c, bcd_out1, err1, exp[3:0], exp[16]); end
      out_ready1 = 1'b1; @(negedge clk); out_ready1 = 1'b0;
    end
    n_cmp++; if (busy1 !== 1'b0) begin
      n_bad++; $display("FAIL sweep_idle busy got=%b want=0", busy1); end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 3; k++) begin
      run_frame4({4'b1011, 4'b1100, 4'b1000, 4'b1111}, 3);
      wait_valid4(ok);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || bcd_out !== 16'h5F89 || bcd_out !== exp[15:0] || err !== 1'b1) begin
        n_bad++; $display("FAIL gaps_result%0d bcd=%h err=%b want bcd=5f89 err=1", k, bcd_out, err); end
      handshake4();
    end
  endtask

  task automatic test_hold();
    run_frame4({4'b0000, 4'b0111, 4'b1111, 4'b1000}, 1);
    wait_valid4(ok);
    exp = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom); din_valid = 1'($urandom); din = 4'($urandom);
      @(negedge clk);
      n_cmp++; if (!ok || out_valid !== 1'b1 || bcd_out !== exp[15:0] || err !== exp[16]) begin
        n_bad++; $display("FAIL hold_cycle%0d ov=%b bcd=%h err=%b want ov=1 bcd=%h err=%b",
                          i, out_valid, bcd_out, err, exp[15:0], exp[16]); end
    end
    start = 1'b0; din_valid = 1'b0;
    handshake4();
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL hold_release busy got=%b want=0", busy); end
  endtask

  task automatic test_abort();
    start = 1'b1; @(negedge clk); start = 1'b0;
    drive_digit(4'b0111, 0);
    drive_digit(4'b1100, 0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || bcd_out !== 16'h0 || err !== 1'b0) begin
      n_bad++; $display("FAIL abort_clear busy=%b bcd=%h err=%b want 0 0000 0", busy, bcd_out, err); end
    start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_vs_start busy got=%b want=0", busy); end
    run_frame4({4'b1001, 4'b1010, 4'b0000, 4'b1111}, 2);
    wait_valid4(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== 16'h7609 || bcd_out !== exp[15:0] || err !== 1'b0) begin
      n_bad++; $display("FAIL abort_next bcd=%h err=%b want bcd=7609 err=0", bcd_out, err); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_done ov=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; @(negedge clk); start = 1'b0;
    drive_digit(4'b1101, 0);
    drive_digit(4'b0110, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({din_ready, out_valid, err, busy} !== 4'b0000 || bcd_out !== 16'h0) begin
      n_bad++; $display("FAIL async_reset flags=%b bcd=%h want 0000 0000", {din_ready, out_valid, err, busy}, bcd_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame4({4'b0100, 4'b0101, 4'b0110, 4'b0111}, 1);
    wait_valid4(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== 16'h4321 || bcd_out !== exp[15:0] || err !== 1'b0) begin
      n_bad++; $display("FAIL async_next bcd=%h err=%b want bcd=4321 err=0", bcd_out, err); end
    handshake4();
  endtask

  task automatic test_back_to_back();
    run_frame4({4'b1000, 4'b1001, 4'b1010, 4'b1011}, 0);
    wait_valid4(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== 16'h8765 || bcd_out !== exp[15:0] || err !== 1'b0) begin
      n_bad++; $display("FAIL b2b_first bcd=%h err=%b want bcd=8765 err=0", bcd_out, err); end
    handshake4();
    run_frame4({4'b1111, 4'b0011, 4'b0000, 4'b0111}, 0);
    n_cmp++; if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_latency out_valid got=%b want=1", out_valid); end
    wait_valid4(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== 16'h9F01 || bcd_out !== exp[15:0] || err !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second bcd=%h err=%b want bcd=9f01 err=1", bcd_out, err); end
    handshake4();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_gaps();
    test_hold();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
